// File: rtl/axi_lite_reg_slave_if.sv
// rtl/axi_lite_reg_slave_if.sv - AXI4-Lite channel bundle for the register slave
interface axi_lite_reg_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// rtl/axi_lite_reg_slave.sv - AXI4-Lite slave: three RW registers and a RO counter status word
module axi_lite_reg_slave #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 4,
  parameter logic [DATA_W-1:0] REG0_RST = '0,
  parameter logic [DATA_W-1:0] REG1_RST = '0,
  parameter logic [DATA_W-1:0] REG2_RST = '0
) (
  input logic                 ACLK,
  input logic                 ARESETn,
  axi_lite_reg_slave_if.slave bus
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] IDX_STATUS  = 2'd3;

  logic              init;
  logic              aw_full;
  logic              w_full;
  logic [ADDR_W-1:0] aw_addr;
  logic [DATA_W-1:0] w_data;
  logic              bvalid;
  logic [1:0]        bresp;
  logic              rvalid;
  logic [1:0]        rresp;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] reg0;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic [15:0]       wr_cnt;
  logic [15:0]       rd_cnt;

  logic              awready;
  logic              wready;
  logic              arready;
  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;
  logic              ar_hs;
  logic              r_hs;
  logic              commit;
  logic              wr_ok;
  logic              rd_ok;
  logic [1:0]        wr_idx;
  logic [1:0]        rd_idx;
  logic [DATA_W-1:0] rd_word;

  // READY outputs stay low until one clock after reset release
  assign awready = init & ~aw_full;
  assign wready  = init & ~w_full;
  assign arready = init & ~rvalid;

  assign aw_hs = bus.AWVALID & awready;
  assign w_hs  = bus.WVALID & wready;
  assign b_hs  = bvalid & bus.BREADY;
  assign ar_hs = bus.ARVALID & arready;
  assign r_hs  = rvalid & bus.RREADY;

  assign wr_idx = aw_addr[3:2];
  assign wr_ok  = (aw_addr[1:0] == 2'b00) && (wr_idx != IDX_STATUS);
  assign commit = aw_full & w_full & ~bvalid;

  assign rd_idx = bus.ARADDR[3:2];
  assign rd_ok  = (bus.ARADDR[1:0] == 2'b00);

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.ARREADY = arready;
  assign bus.BVALID  = bvalid;
  assign bus.BRESP   = bresp;
  assign bus.RVALID  = rvalid;
  assign bus.RRESP   = rresp;
  assign bus.RDATA   = rdata;

  // STATUS reports counts as they stood before this edge's updates
  always_comb begin
    rd_word = '0;
    case (rd_idx)
      2'd0:    rd_word = reg0;
      2'd1:    rd_word = reg1;
      2'd2:    rd_word = reg2;
      default: rd_word = {wr_cnt, rd_cnt};
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      init <= 1'b0;
    end else begin
      init <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_full <= 1'b0;
      aw_addr <= '0;
    end else if (aw_hs) begin
      aw_full <= 1'b1;
      aw_addr <= bus.AWADDR;
    end else if (commit) begin
      aw_full <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_full <= 1'b0;
      w_data <= '0;
    end else if (w_hs) begin
      w_full <= 1'b1;
      w_data <= bus.WDATA;
    end else if (commit) begin
      w_full <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else if (commit) begin
      bvalid <= 1'b1;
      bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (b_hs) begin
      bvalid <= 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      reg0 <= REG0_RST;
      reg1 <= REG1_RST;
      reg2 <= REG2_RST;
    end else if (commit && wr_ok) begin
      case (wr_idx)
        2'd0:    reg0 <= w_data;
        2'd1:    reg1 <= w_data;
        2'd2:    reg2 <= w_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_cnt <= '0;
    end else if (commit && wr_ok) begin
      wr_cnt <= wr_cnt + 16'd1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_cnt <= '0;
    end else if (ar_hs && rd_ok) begin
      rd_cnt <= rd_cnt + 16'd1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      rdata  <= rd_ok ? rd_word : '0;
    end else if (r_hs) begin
      rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// tb/tb_axi_lite_reg_slave.sv - self-checking bench for axi_lite_reg_slave
module tb_axi_lite_reg_slave;
  logic aclk;
  logic aresetn;

  axi_lite_reg_slave_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  axi_lite_reg_slave #(
    .DATA_W(32), .ADDR_W(4),
    .REG0_RST(32'h0), .REG1_RST(32'h0), .REG2_RST(32'h0)
  ) dut (
    .ACLK(aclk),
    .ARESETn(aresetn),
    .bus(bus.slave)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [3];
  logic [15:0] m_wr;
  logic [15:0] m_rd;

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_regs[i] = 32'h0;
    m_wr = 16'h0;
    m_rd = 16'h0;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [31:0] d, output logic [1:0] resp);
    int idx;
    idx = int'(a) / 4;
    if ((int'(a) % 4 == 0) && idx < 3) begin
      m_regs[idx] = d;
      m_wr = m_wr + 16'd1;
      resp = 2'b00;
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic model_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    int idx;
    idx = int'(a) / 4;
    if (int'(a) % 4 != 0) begin
      d = 32'h0;
      resp = 2'b10;
    end else begin
      d = (idx == 3) ? {m_wr, m_rd} : m_regs[idx];
      resp = 2'b00;
      m_rd = m_rd + 16'd1;
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input int aw_dly,
                           input int w_dly, output logic [1:0] resp);
    int c;
    bit aw_done, w_done, awh, wh;
    aw_done = 0; w_done = 0; c = 0;
    @(negedge aclk);
    bus.BREADY = 1'b1;
    while (!(aw_done && w_done) && c < 40) begin
      if (!aw_done && c >= aw_dly) begin bus.AWADDR = a; bus.AWVALID = 1'b1; end
      if (!w_done && c >= w_dly) begin bus.WDATA = d; bus.WVALID = 1'b1; end
      awh = bus.AWVALID && bus.AWREADY;
      wh  = bus.WVALID && bus.WREADY;
      @(negedge aclk);
      c++;
      if (awh) begin bus.AWVALID = 1'b0; aw_done = 1; end
      if (wh)  begin bus.WVALID = 1'b0;  w_done = 1;  end
    end
    c = 0;
    while (!bus.BVALID && c < 20) begin
      @(negedge aclk);
      c++;
    end
    if (!bus.BVALID) begin
      check("write_timeout", {31'h0, bus.BVALID}, 32'h1);
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      resp = 2'bxx;
    end else begin
      resp = bus.BRESP;
      @(negedge aclk);
    end
  endtask

  task automatic axi_read(input logic [3:0] a, input int ar_dly,
                          output logic [31:0] d, output logic [1:0] resp);
    int c;
    bit done, arh;
    done = 0; c = 0;
    @(negedge aclk);
    bus.RREADY = 1'b1;
    while (!done && c < 40) begin
      if (c >= ar_dly) begin bus.ARADDR = a; bus.ARVALID = 1'b1; end
      arh = bus.ARVALID && bus.ARREADY;
      @(negedge aclk);
      c++;
      if (arh) begin bus.ARVALID = 1'b0; done = 1; end
    end
    if (!done || !bus.RVALID) begin
      check("read_timeout", {31'h0, bus.RVALID}, 32'h1);
      bus.ARVALID = 1'b0;
      d = 32'hx;
      resp = 2'bxx;
    end else begin
      d = bus.RDATA;
      resp = bus.RRESP;
      @(negedge aclk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    logic [3:0]  a;

    aresetn = 1'b0;
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    model_reset();

    vecs[0]  = '{0, 4'h0, 32'h0,        2'b00, 32'h0000_0000};
    vecs[1]  = '{0, 4'h4, 32'h0,        2'b00, 32'h0000_0000};
    vecs[2]  = '{0, 4'h8, 32'h0,        2'b00, 32'h0000_0000};
    vecs[3]  = '{0, 4'hC, 32'h0,        2'b00, 32'h0000_0003};
    vecs[4]  = '{1, 4'h4, 32'h0BAD_F00D, 2'b00, 32'h0};
    vecs[5]  = '{0, 4'h4, 32'h0,        2'b00, 32'h0BAD_F00D};
    vecs[6]  = '{1, 4'hC, 32'hFFFF_FFFF, 2'b10, 32'h0};
    vecs[7]  = '{0, 4'hC, 32'h0,        2'b00, 32'h0001_0005};
    vecs[8]  = '{0, 4'h2, 32'h0,        2'b10, 32'h0000_0000};
    vecs[9]  = '{1, 4'h1, 32'h0000_AAAA, 2'b10, 32'h0};
    vecs[10] = '{1, 4'h0, 32'h0000_0011, 2'b00, 32'h0};
    vecs[11] = '{0, 4'h0, 32'h0,        2'b00, 32'h0000_0011};
    vecs[12] = '{0, 4'hC, 32'h0,        2'b00, 32'h0002_0007};
    vecs[13] = '{0, 4'h7, 32'h0,        2'b10, 32'h0000_0000};

    // Reset state and READY release timing
    repeat (3) @(negedge aclk);
    check("rst_awready", {31'h0, bus.AWREADY}, 32'h0);
    check("rst_bvalid",  {31'h0, bus.BVALID},  32'h0);
    check("rst_rvalid",  {31'h0, bus.RVALID},  32'h0);
    check("rst_rdata",   bus.RDATA, 32'h0);
    check("rst_resps",   {28'h0, bus.BRESP, bus.RRESP}, 32'h0);
    aresetn = 1'b1;
    #1;
    check("rel_ready_low", {29'h0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'h0);
    @(negedge aclk);
    check("rel_ready_high", {29'h0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'h7);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].wdata, 0, 0, r);
        model_write(vecs[i].addr, vecs[i].wdata, er);
        check($sformatf("vec%0d_bresp", i), {30'h0, r}, {30'h0, vecs[i].exp_resp});
      end else begin
        axi_read(vecs[i].addr, 0, d, r);
        model_read(vecs[i].addr, ed, er);
        check($sformatf("vec%0d_rresp", i), {30'h0, r}, {30'h0, vecs[i].exp_resp});
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp_rdata);
      end
    end

    // AW and W together: BVALID one edge after the handshake edge
    @(negedge aclk);
    bus.AWADDR = 4'h4; bus.WDATA = 32'hDEAD_BEEF; bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    bus.BREADY = 1'b1;
    check("a_ready", {30'h0, bus.AWREADY, bus.WREADY}, 32'h3);
    @(negedge aclk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check("a_bvalid_early", {31'h0, bus.BVALID}, 32'h0);
    @(negedge aclk);
    check("a_bvalid", {31'h0, bus.BVALID}, 32'h1);
    check("a_bresp", {30'h0, bus.BRESP}, 32'h0);
    @(negedge aclk);
    check("a_bvalid_clr", {31'h0, bus.BVALID}, 32'h0);
    model_write(4'h4, 32'hDEAD_BEEF, er);
    axi_read(4'h4, 0, d, r);
    model_read(4'h4, ed, er);
    check("a_rdata", d, 32'hDEAD_BEEF);
    check("a_rresp", {30'h0, r}, 32'h0);

    // W three cycles ahead of AW, response held off by BREADY
    @(negedge aclk);
    bus.WDATA = 32'h1234_5678; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
    @(negedge aclk);
    bus.WVALID = 1'b0;
    check("b_wready_drop", {31'h0, bus.WREADY}, 32'h0);
    @(negedge aclk);
    @(negedge aclk);
    bus.AWADDR = 4'h8; bus.AWVALID = 1'b1;
    @(negedge aclk);
    bus.AWVALID = 1'b0;
    check("b_bvalid_early", {31'h0, bus.BVALID}, 32'h0);
    @(negedge aclk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("b_hold%0d", k), {29'h0, bus.BVALID, bus.BRESP}, 32'h4);
      if (k < 4) @(negedge aclk);
    end
    bus.BREADY = 1'b1;
    @(negedge aclk);
    check("b_bvalid_clr", {31'h0, bus.BVALID}, 32'h0);
    model_write(4'h8, 32'h1234_5678, er);
    axi_read(4'h8, 0, d, r);
    model_read(4'h8, ed, er);
    check("b_reg2", d, 32'h1234_5678);

    // Read of REG0 on the same edge as a write commit to REG0
    @(negedge aclk);
    bus.AWADDR = 4'h0; bus.WDATA = 32'h55; bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    bus.BREADY = 1'b1; bus.RREADY = 1'b1; bus.ARADDR = 4'h0;
    @(negedge aclk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b1;
    @(negedge aclk);
    bus.ARVALID = 1'b0;
    check("c_rvalid", {31'h0, bus.RVALID}, 32'h1);
    check("c_rdata_old", bus.RDATA, 32'h11);
    check("c_bvalid", {31'h0, bus.BVALID}, 32'h1);
    model_read(4'h0, ed, er);
    model_write(4'h0, 32'h55, er);
    @(negedge aclk);
    axi_read(4'h0, 0, d, r);
    model_read(4'h0, ed, er);
    check("c_rdata_new", d, 32'h55);
    axi_read(4'hC, 0, d, r);
    model_read(4'hC, ed, er);
    check("c_status", d, ed);

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        axi_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), r);
        model_write(a, d, er);
        check($sformatf("rnd%0d_wr_a%h_bresp", i, a), {30'h0, r}, {30'h0, er});
      end else begin
        axi_read(a, $urandom_range(0, 3), d, r);
        model_read(a, ed, er);
        check($sformatf("rnd%0d_rd_a%h_rresp", i, a), {30'h0, r}, {30'h0, er});
        check($sformatf("rnd%0d_rd_a%h_rdata", i, a), d, ed);
      end
    end

    // Write counter wrap: preload near the top, then cross 0xFFFF
    @(negedge aclk);
    force dut.wr_cnt = 16'hFFFD;
    @(negedge aclk);
    release dut.wr_cnt;
    m_wr = 16'hFFFD;
    for (int i = 0; i < 3; i++) begin
      axi_write(4'h0, 32'(i), 0, 0, r);
      model_write(4'h0, 32'(i), er);
      check($sformatf("wrap_bresp%0d", i), {30'h0, r}, 32'h0);
    end
    axi_read(4'hC, 0, d, r);
    model_read(4'hC, ed, er);
    check("wrap_status", d, ed);
    check("wrap_wr_cnt", {16'h0, d[31:16]}, 32'h0);

    // Reset while BVALID is pending drops the response at once
    @(negedge aclk);
    bus.AWADDR = 4'h4; bus.WDATA = 32'hA5A5; bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    bus.BREADY = 1'b0;
    @(negedge aclk);
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    @(negedge aclk);
    check("e_bvalid_pending", {31'h0, bus.BVALID}, 32'h1);
    #2 aresetn = 1'b0;
    #1;
    check("e_bvalid_async", {31'h0, bus.BVALID}, 32'h0);
    check("e_ready_async", {29'h0, bus.AWREADY, bus.WREADY, bus.ARREADY}, 32'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    bus.BREADY = 1'b1;
    model_reset();
    repeat (3) @(negedge aclk);
    check("e_no_response", {31'h0, bus.BVALID}, 32'h0);

    // A lone AW latched before reset must not pair with a later W
    bus.AWADDR = 4'h0; bus.AWVALID = 1'b1;
    @(negedge aclk);
    bus.AWVALID = 1'b0;
    #2 aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    bus.WDATA = 32'h0BEE_F00D; bus.WVALID = 1'b1;
    @(negedge aclk);
    bus.WVALID = 1'b0;
    repeat (3) @(negedge aclk);
    check("e_w_alone", {31'h0, bus.BVALID}, 32'h0);
    bus.AWADDR = 4'h8; bus.AWVALID = 1'b1;
    @(negedge aclk);
    bus.AWVALID = 1'b0;
    @(negedge aclk);
    check("e_pair_bvalid", {29'h0, bus.BVALID, bus.BRESP}, 32'h4);
    @(negedge aclk);
    model_write(4'h8, 32'h0BEE_F00D, er);
    axi_read(4'h0, 0, d, r);
    model_read(4'h0, ed, er);
    check("e_reg0", d, 32'h0);
    axi_read(4'h8, 0, d, r);
    model_read(4'h8, ed, er);
    check("e_reg2", d, 32'h0BEE_F00D);
    axi_read(4'hC, 0, d, r);
    model_read(4'hC, ed, er);
    check("e_status", d, 32'h0001_0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_lite_reg_slave.md
Name: axi_lite_reg_slave

Overview:
AXI4-Lite responder that terminates the AXI_Lite_Master channels in a small memory-mapped register block.
- Three read/write control registers, plus one read-only status register holding transaction counters.
- Address and write data are captured independently, in either order.
- Illegal accesses return SLVERR.
- Plugs into the top-level AXI wiring as a drop-in peer to AXI_Lite_Slave, using the same signal names.

Parameters:
DATA_W  32  data bus width; fixed at 32 (status register layout depends on it)
ADDR_W  4  byte address width; 4 word slots at 0x0, 0x4, 0x8, 0xC
REG0_RST  32'h0  reset value of REG0 (0x0)
REG1_RST  32'h0  reset value of REG1 (0x4)
REG2_RST  32'h0  reset value of REG2 (0x8)

Ports:
ACLK  in  1  clock, rising edge
ARESETn  in  1  asynchronous active-low reset
AWADDR  in  ADDR_W  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_W  write data
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response: 00 OKAY, 10 SLVERR
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_W  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_W  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready

Behaviour:
Register map:
- 0x0 REG0, 0x4 REG1, 0x8 REG2: RW.
- 0xC STATUS: RO, {wr_cnt[15:0], rd_cnt[15:0]}.

Reset (ARESETn low, takes effect immediately):
- BVALID, RVALID = 0; BRESP, RRESP, RDATA = 0.
- REGn = REGn_RST; counters = 0; aw_full, w_full = 0.
- init flop = 0. All READY outputs are gated by init, so they are 0 during reset and on the first edge after release.
- Reset mid-transaction drops any latched AW/W and any pending B/R with no response issued.

Write path:
- AWREADY = init & ~aw_full. An AW handshake latches AWADDR and sets aw_full.
- WREADY = init & ~w_full. A W handshake latches WDATA and sets w_full.
- AW and W may arrive in either order or in the same cycle.
- Commit edge: the first edge with aw_full & w_full & ~BVALID.
  - Addr[1:0] != 0, or address 0xC: no register change, BRESP = 10.
  - Otherwise: the target REG takes the latched data, BRESP = 00, wr_cnt++.
  - On the same edge: BVALID <= 1, aw_full <= 0, w_full <= 0.
- Minimum latency: AW+W handshake at edge N, BVALID high after edge N+1.
- BVALID and BRESP hold until the BREADY handshake, which clears BVALID.
- A new AW/W may be latched while BVALID is pending; its commit waits until BVALID is 0.

Read path:
- ARREADY = init & ~RVALID.
- On an AR handshake at edge N, RDATA and RRESP are registered and RVALID = 1 after edge N. The read is a single-cycle response.
- Address with addr[1:0] != 0: RDATA = 0, RRESP = 10, rd_cnt unchanged.
- Otherwise: RRESP = 00 and rd_cnt++. A STATUS read returns the pre-increment counts.
- RDATA, RRESP and RVALID hold until the RREADY handshake.

Simultaneous events:
- Read and write commit on the same register at the same edge: the read returns the old value.
- A write commit and a read on the same edge: both counters update.
- Counters are 16 bits, wrap 0xFFFF -> 0x0000, and only count OKAY transactions.

Test Plan:
- Reset release -> all READY 0 on the first edge, then AWREADY = WREADY = ARREADY = 1. BVALID = RVALID = 0; REG0..2 = RST values; STATUS = 0.
- AW = 0x4 and W = 0xDEADBEEF in the same cycle, BREADY = 1 -> BVALID one edge later with BRESP = 00. Read of 0x4 returns 0xDEADBEEF, RRESP = 00.
- W = 0x12345678 three cycles before AW = 0x8, with BREADY held 0 for 5 cycles -> WREADY drops after the W handshake. BVALID stays high and stable until BREADY. REG2 = 0x12345678.
- Write to 0xC with data 0xFFFFFFFF -> BRESP = 10 and STATUS is unchanged. Read of 0x2 -> RRESP = 10, RDATA = 0.
- Read of 0x0 issued on the same edge as a write commit of 0x55 to 0x0 (REG0 previously 0x11) -> RDATA = 0x11. A subsequent read returns 0x55.
- 65536 OKAY writes -> wr_cnt wraps to 0x0000. Asserting ARESETn low while BVALID is pending -> BVALID drops immediately and no response is issued.
